// File: rtl/zap_wb_pkg.sv
// Shared types for the Wishbone command master: FSM encoding, command record
// and default parameters.
package zap_wb_pkg;

  localparam int TIMEOUT_DEFAULT   = 16;
  localparam int CMD_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        wen;
    logic [3:0]  sel;
  } wb_cmd_t;

  localparam int CMD_W = $bits(wb_cmd_t);

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous FIFO with show-ahead read data; pushes while full and pops
// while empty are ignored.
module wb_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_full_next,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_rdata = mem_q[rd_ptr_q];

  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + AW'(do_push);
    rd_ptr_d    = rd_ptr_q + AW'(do_pop);
    count_d     = count_q + CW'(do_push) - CW'(do_pop);
    o_full_next = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; emptiness is tracked by count_q,
  // so stale entries are never observed and the array can map to plain RAM.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_wdata;
  end

endmodule

// File: rtl/wb_cmd_master.sv
// Queues read/write commands and issues them one at a time as Wishbone
// classic cycles, returning data or a timeout error per command.
module wb_cmd_master
  import zap_wb_pkg::*;
#(
  parameter int CMD_DEPTH = CMD_DEPTH_DEFAULT,
  parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [31:0] i_cmd_adr,
  input  logic [31:0] i_cmd_dat,
  input  logic        i_cmd_wen,
  input  logic [3:0]  i_cmd_sel,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_dat,
  output logic        o_rsp_err,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_wen,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  output logic        o_busy
);

  wb_state_e   state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic        cyc_q, cyc_d;
  wb_cmd_t     wb_cmd_q, wb_cmd_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        rsp_err_q, rsp_err_d;
  logic        cmd_ready_q, cmd_ready_d;

  wb_cmd_t                    cmd_in;
  logic [CMD_W-1:0]           fifo_rdata;
  logic                       fifo_push, fifo_pop;
  logic                       fifo_full, fifo_full_next, fifo_empty;
  logic [$clog2(CMD_DEPTH):0] fifo_count;

  assign cmd_in    = '{adr: i_cmd_adr, dat: i_cmd_dat, wen: i_cmd_wen, sel: i_cmd_sel};
  assign fifo_push = i_cmd_valid && cmd_ready_q;

  wb_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (fifo_push),
    .i_wdata     (cmd_in),
    .i_pop       (fifo_pop),
    .o_rdata     (fifo_rdata),
    .o_full      (fifo_full),
    .o_full_next (fifo_full_next),
    .o_empty     (fifo_empty),
    .o_count     (fifo_count)
  );

  // NOTE: every signal written here gets its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cyc_d       = cyc_q;
    wb_cmd_d    = wb_cmd_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;
    // The ready flag tracks the FIFO occupancy that will hold after this edge.
    cmd_ready_d = !fifo_full_next;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          wb_cmd_d = wb_cmd_t'(fifo_rdata);
          cyc_d    = 1'b1;
          timer_d  = '0;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        // A late ack on the expiry edge still completes the cycle normally.
        if (i_wb_ack) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = wb_cmd_q.wen ? 32'h0 : i_wb_dat;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = 32'h0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      ST_RSP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, whatever the statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      cyc_q       <= 1'b0;
      wb_cmd_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cyc_q       <= cyc_d;
      wb_cmd_q    <= wb_cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign o_cmd_ready = cmd_ready_q && !fifo_full;
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = cyc_q;
  assign o_wb_wen    = wb_cmd_q.wen;
  assign o_wb_adr    = wb_cmd_q.adr;
  assign o_wb_dat    = wb_cmd_q.dat;
  assign o_wb_sel    = wb_cmd_q.sel;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_dat   = rsp_dat_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_busy      = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: a small register-bank responder plus
// a transaction-level model of expected responses and bus cycles.
module tb_wb_cmd_master;

  localparam int TIMEOUT = 16;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic [31:0] i_cmd_adr = '0;
  logic [31:0] i_cmd_dat = '0;
  logic        i_cmd_wen = 1'b0;
  logic [3:0]  i_cmd_sel = '0;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] i_wb_dat = '0;
  logic        i_wb_ack;
  logic        o_cmd_ready, o_rsp_valid, o_rsp_err, o_busy;
  logic        o_wb_cyc, o_wb_stb, o_wb_wen;
  logic [31:0] o_rsp_dat, o_wb_adr, o_wb_dat;
  logic [3:0]  o_wb_sel;

  wb_cmd_master #(.CMD_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_adr(i_cmd_adr), .i_cmd_dat(i_cmd_dat), .i_cmd_wen(i_cmd_wen), .i_cmd_sel(i_cmd_sel),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_dat(o_rsp_dat), .o_rsp_err(o_rsp_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_wen(o_wb_wen),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
    .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        wen;
    logic [3:0]  sel;
  } bus_t;

  typedef struct {
    bus_t        cmd;
    logic [31:0] rdat;
    logic        err;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  bus_t cyc_log[$];
  logic [31:0] model_mem [4];

  // Responder state: a four-word register bank (word 1 is the VIC mask).
  logic [31:0] resp_mem [4];
  int   delay = 0;
  bit   noack = 1'b0;
  bit   force_ack = 1'b0;
  bit   resp_ack = 1'b0;
  bit   in_cyc = 1'b0;
  int   wait_cnt = 0;
  int   stable_viol = 0;
  bus_t start_b;

  assign i_wb_ack = resp_ack | force_ack;

  function automatic logic [31:0] sel_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
    return m;
  endfunction

  always @(negedge i_clk) begin
    resp_ack = 1'b0;
    i_wb_dat = $urandom();
    if (!o_wb_cyc) begin
      in_cyc   = 1'b0;
      wait_cnt = 0;
    end else begin
      if (!in_cyc) begin
        in_cyc  = 1'b1;
        start_b = '{adr: o_wb_adr, dat: o_wb_dat, wen: o_wb_wen, sel: o_wb_sel};
        cyc_log.push_back(start_b);
      end else if (o_wb_adr !== start_b.adr || o_wb_dat !== start_b.dat ||
                   o_wb_wen !== start_b.wen || o_wb_sel !== start_b.sel || !o_wb_stb) begin
        stable_viol++;
      end
      if (!noack && wait_cnt == delay) begin
        resp_ack = 1'b1;
        if (o_wb_wen) begin
          resp_mem[o_wb_adr[3:2]] = (resp_mem[o_wb_adr[3:2]] & ~sel_mask(o_wb_sel)) |
                                    (o_wb_dat & sel_mask(o_wb_sel));
          i_wb_dat = 32'hDEAD_BEEF;
        end else begin
          i_wb_dat = resp_mem[o_wb_adr[3:2]];
        end
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the push edge.
  task automatic push(input logic [31:0] adr, input logic [31:0] dat, input logic wen,
                      input logic [3:0] sel);
    int   w = 0;
    exp_t e;
    logic [1:0] idx;
    while (!o_cmd_ready && w < 300) begin
      @(negedge i_clk);
      w++;
    end
    check("push_ready", o_cmd_ready, 1);
    if (o_cmd_ready) begin
      idx   = adr[3:2];
      e.cmd = '{adr: adr, dat: dat, wen: wen, sel: sel};
      e.err = noack || (delay + 1 > TIMEOUT);
      e.rdat = 32'h0;
      if (!e.err) begin
        if (wen) model_mem[idx] = (model_mem[idx] & ~sel_mask(sel)) | (dat & sel_mask(sel));
        else     e.rdat = model_mem[idx];
      end
      exp_q.push_back(e);
    end
    i_cmd_valid = 1'b1;
    i_cmd_adr   = adr;
    i_cmd_dat   = dat;
    i_cmd_wen   = wen;
    i_cmd_sel   = sel;
    @(posedge i_clk);
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    int   w = 0;
    exp_t e;
    bus_t b;
    logic [31:0] d0;
    while (!o_rsp_valid && w < 300) begin
      @(negedge i_clk);
      w++;
    end
    check("rsp_valid", o_rsp_valid, 1);
    check("rsp_expected", 32'(exp_q.size() != 0), 1);
    if (exp_q.size() == 0) return;
    e  = exp_q.pop_front();
    d0 = o_rsp_dat;
    check("cyc_low_in_rsp", o_wb_cyc, 0);
    repeat (hold) @(negedge i_clk);
    if (hold > 0) begin
      check("rsp_hold_valid", o_rsp_valid, 1);
      check("rsp_hold_dat", o_rsp_dat, d0);
    end
    check("rsp_dat", o_rsp_dat, e.rdat);
    check("rsp_err", o_rsp_err, e.err);
    check("bus_logged", 32'(cyc_log.size() != 0), 1);
    if (cyc_log.size() != 0) begin
      b = cyc_log.pop_front();
      check("bus_adr", b.adr, e.cmd.adr);
      check("bus_dat", b.dat, e.cmd.dat);
      check("bus_wen", b.wen, e.cmd.wen);
      check("bus_sel", b.sel, e.cmd.sel);
    end
    i_rsp_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    check("rsp_released", o_rsp_valid, 0);
  endtask

  // Single command into an idle block with a zero-wait responder: stb after
  // the edge following the push, response after the edge after that.
  task automatic run_single(input logic [31:0] adr, input logic [31:0] dat, input logic wen,
                            input logic [3:0] sel);
    push(adr, dat, wen, sel);
    @(posedge i_clk);
    @(negedge i_clk);
    check("lat_stb", o_wb_stb, 1);
    check("lat_cyc", o_wb_cyc, 1);
    check("lat_wen", o_wb_wen, wen);
    @(posedge i_clk);
    @(negedge i_clk);
    check("lat_rsp_valid", o_rsp_valid, 1);
    check("lat_stb_drop", o_wb_stb, 0);
    collect(0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, saw, edges;
    logic [31:0] r;
    resp_mem  = '{32'h0000_0003, 32'h0000_0000, 32'h1234_5678, 32'hA5A5_0F0F};
    model_mem = '{32'h0000_0003, 32'h0000_0000, 32'h1234_5678, 32'hA5A5_0F0F};

    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_cmd_ready", o_cmd_ready, 0);
    check("rst_cyc", o_wb_cyc, 0);
    check("rst_stb", o_wb_stb, 0);
    check("rst_rsp_valid", o_rsp_valid, 0);
    check("rst_rsp_dat", o_rsp_dat, 0);
    check("rst_wb_adr", o_wb_adr, 0);
    check("rst_busy", o_busy, 0);
    i_rst = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    check("post_rst_ready", o_cmd_ready, 1);

    // Write the VIC mask, then read the status word
    run_single(32'h4, 32'hFFFF_FFFE, 1'b1, 4'hF);
    check("vic_mask", resp_mem[1], 32'hFFFF_FFFE);
    run_single(32'h0, 32'h0, 1'b0, 4'hF);

    // Timeout: cyc drops exactly TIMEOUT edges after stb rises
    noack = 1'b1;
    push(32'hC, 32'h0, 1'b0, 4'hF);
    @(posedge i_clk);
    @(negedge i_clk);
    check("to_stb_rise", o_wb_stb, 1);
    edges = 0;
    while (o_wb_cyc && edges < 40) begin
      @(posedge i_clk);
      @(negedge i_clk);
      edges++;
    end
    check("to_edges", edges, TIMEOUT);
    collect(1);
    noack = 1'b0;

    // Ack on the expiry edge wins; one edge later the timeout wins
    delay = TIMEOUT - 1;
    push(32'h8, 32'h0, 1'b0, 4'hF);
    collect(0);
    delay = TIMEOUT;
    push(32'h8, 32'h0, 1'b0, 4'hF);
    collect(0);

    // Backpressure: the first command sits in RSP, the next four fill the FIFO
    delay = 0;
    for (int i = 0; i < 5; i++) push(32'h10 + 32'(i) * 4, 32'h100 + 32'(i), 1'b1, 4'h1 << (i % 4));
    check("bp_ready_low", o_cmd_ready, 0);
    i_cmd_valid = 1'b1;
    i_cmd_adr   = 32'hBAD0;
    i_cmd_wen   = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
    check("bp_refused_ready", o_cmd_ready, 0);
    for (int i = 0; i < 5; i++) collect(i % 3);
    saw = 0;
    repeat (20) begin
      @(negedge i_clk);
      saw |= int'(o_rsp_valid) | int'(o_wb_cyc);
    end
    check("bp_no_extra", saw, 0);
    check("bp_idle_busy", o_busy, 0);

    // Reset while in REQ with commands queued behind it
    noack = 1'b1;
    for (int i = 0; i < 3; i++) push(32'h0, 32'h0, 1'b0, 4'hF);
    check("rq_in_req", o_wb_cyc, 1);
    i_rst = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    check("rq_cyc", o_wb_cyc, 0);
    check("rq_stb", o_wb_stb, 0);
    check("rq_rsp_valid", o_rsp_valid, 0);
    check("rq_busy", o_busy, 0);
    i_rst = 1'b0;
    exp_q.delete();
    cyc_log.delete();
    force_ack = 1'b1;
    saw = 0;
    repeat (4) begin
      @(negedge i_clk);
      saw |= int'(o_rsp_valid) | int'(o_wb_cyc);
    end
    force_ack = 1'b0;
    repeat (10) begin
      @(negedge i_clk);
      saw |= int'(o_rsp_valid) | int'(o_wb_cyc) | int'(o_busy);
    end
    check("rq_late_ack_ignored", saw, 0);
    check("rq_ready_back", o_cmd_ready, 1);
    noack = 1'b0;

    // Randomized batches against the model
    for (int b = 0; b < 10; b++) begin
      delay = $urandom_range(0, 3);
      n     = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        r = $urandom();
        push({r[31:4], 2'(r[5:4] ^ r[1:0]), 2'b00}, $urandom(), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)));
      end
      for (int i = 0; i < n; i++) collect($urandom_range(0, 2));
    end

    check("wb_stable", stable_viol, 0);
    check("final_idle", o_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
